// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the chunked adder datapaths.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int num_chunks(input int size, input int chunk);
    return size / chunk;
  endfunction

  // A single-chunk configuration still needs a 1-bit index register.
  function automatic int idx_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// Combinational full-adder chain of SIZE bits with carry in and carry out.
module ripple_carry_adder #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            c_in,
  output logic [SIZE-1:0] sum,
  output logic            c_out
);

  logic [SIZE:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < SIZE; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign c_out = c[SIZE];

endmodule

// File: rtl/sequential_ripple_carry_adder.sv
// Multi-cycle adder: sum = a + b + c_in, CHUNK bits per clock with a registered
// inter-chunk carry; operands and result use valid/ready handshakes.
module sequential_ripple_carry_adder
  import adder_pkg::*;
#(
  parameter int SIZE  = 32,
  parameter int CHUNK = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [SIZE-1:0] i_a,
  input  logic [SIZE-1:0] i_b,
  input  logic            i_c_in,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [SIZE-1:0] o_sum,
  output logic            o_c_out,
  output logic            o_busy
);

  localparam int NCHUNK = num_chunks(SIZE, CHUNK);
  localparam int IDXW   = idx_width(NCHUNK);

  if (SIZE % CHUNK != 0) begin : g_bad_chunk
    $error("sequential_ripple_carry_adder: SIZE (%0d) must be a multiple of CHUNK (%0d)",
           SIZE, CHUNK);
  end

  state_t            state;
  state_t            state_next;
  logic [SIZE-1:0]   a_reg;
  logic [SIZE-1:0]   b_reg;
  logic              carry_reg;
  logic [IDXW-1:0]   idx;
  logic [31:0]       base;
  logic              last_chunk;
  logic [CHUNK-1:0]  a_chunk;
  logic [CHUNK-1:0]  b_chunk;
  logic [CHUNK-1:0]  s_chunk;
  logic              c_chunk;

  assign base       = 32'(idx) * 32'(CHUNK);
  assign last_chunk = (idx == IDXW'(NCHUNK - 1));
  assign a_chunk    = a_reg[base +: CHUNK];
  assign b_chunk    = b_reg[base +: CHUNK];

  ripple_carry_adder #(
    .SIZE(CHUNK)
  ) u_chunk_add (
    .a     (a_chunk),
    .b     (b_chunk),
    .c_in  (carry_reg),
    .sum   (s_chunk),
    .c_out (c_chunk)
  );

  // Handshake outputs decode state directly so reset clears them asynchronously.
  assign o_ready = (state == IDLE);
  assign o_valid = (state == DONE);
  assign o_busy  = (state != IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_valid)    state_next = RUN;
      RUN:     if (last_chunk) state_next = DONE;
      DONE:    if (i_ready)    state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      o_sum     <= '0;
      o_c_out   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            a_reg     <= i_a;
            b_reg     <= i_b;
            carry_reg <= i_c_in;
            idx       <= '0;
            o_sum     <= '0;
          end
        end
        RUN: begin
          o_sum[base +: CHUNK] <= s_chunk;
          carry_reg            <= c_chunk;
          idx                  <= idx + IDXW'(1);
          if (last_chunk) begin
            o_c_out <= c_chunk;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
